fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Parametrised successor to the pipeline's combinational forwarding logic.
- Merges three functions in one block:
  - EX-stage operand forwarding (MEM over WB priority) and store-data forwarding.
  - Load-use hazard detection, with a multi-cycle stall FSM sized by load latency.
  - Taken-branch flush control.
- Also keeps saturating stall and flush performance counters.
- Sits beside the ID/EX/MEM/WB pipeline registers and drives their stall, flush and bubble controls.

Parameters:
- RADDR_W, 5, register-address width (number of GPRs = 2**RADDR_W).
- LOAD_LAT, 1, stall cycles a load-use hazard costs; legal range 1..7.
- CNT_W, 32, width of StallCnt and FlushCnt.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- Ra_ID  in  RADDR_W  source A of the instruction in ID
- Rb_ID  in  RADDR_W  source B of the instruction in ID
- UseRb_ID  in  1  ID instruction actually reads Rb
- RegWr_EX  in  1  EX instruction writes a register
- MemRd_EX  in  1  EX instruction is a load
- Rd_EX  in  RADDR_W  destination of the EX instruction
- Ra_EX  in  RADDR_W  source A in EX
- Rb_EX  in  RADDR_W  source B in EX
- BrTaken_EX  in  1  branch/jump resolved taken in EX
- RegWr_M  in  1  MEM instruction writes a register
- MemWr_M  in  1  MEM instruction is a store
- Rd_M  in  RADDR_W  destination of the MEM instruction
- Rb_M  in  RADDR_W  store-data source register in MEM
- RegWr_WB  in  1  WB instruction writes a register
- Rd_WB  in  RADDR_W  destination of the WB instruction
- BusAFw  out  2  operand-A mux select: 00 regfile, 10 MEM result, 01 WB result
- BusBFw  out  2  operand-B mux select, same encoding as BusAFw
- DiSrc  out  1  store data in MEM comes from the WB result
- Stall_IF  out  1  hold PC and IF/ID
- Stall_ID  out  1  hold ID/EX source fields
- Bubble_EX  out  1  load a NOP into ID/EX
- Flush_ID  out  1  squash IF/ID
- StallCnt  out  CNT_W  cycles with Stall_ID=1, saturating
- FlushCnt  out  CNT_W  cycles with Flush_ID=1, saturating

Behaviour:
- Register 0 is never a forwarding or hazard source: every match term requires the register address to be nonzero.
- Forwarding, combinational, for X in {A,B}:
  - hitM = RegWr_M & Rd_M!=0 & Rd_M==Rx_EX.
  - hitW = RegWr_WB & Rd_WB!=0 & Rd_WB==Rx_EX.
  - Select = 10 if hitM; else 01 if hitW; else 00. Never 11.
  - WB is suppressed only when MEM actually hits (qualified by RegWr_M), not on a bare address match.
- DiSrc = MemWr_M & RegWr_WB & Rd_WB!=0 & Rd_WB==Rb_M.
- Load-use detect, combinational:
  - lu = MemRd_EX & RegWr_EX & Rd_EX!=0 & (Rd_EX==Ra_ID | (UseRb_ID & Rd_EX==Rb_ID)).
- FSM states: IDLE, LU_WAIT. 3-bit down-counter cnt.
  - IDLE, BrTaken_EX=1: Flush_ID=1, Bubble_EX=1, Stall_*=0. Flush has priority over lu, since the ID instruction is squashed. Stay in IDLE.
  - IDLE, lu=1, no branch: Stall_IF=Stall_ID=Bubble_EX=1 this cycle.
    - LOAD_LAT==1: stay in IDLE.
    - Otherwise: go to LU_WAIT with cnt=LOAD_LAT-1.
  - LU_WAIT: Stall_IF=Stall_ID=Bubble_EX=1 and cnt decrements each cycle. When cnt==1, return to IDLE next cycle.
  - LU_WAIT ignores lu and BrTaken_EX; EX holds a bubble, so both are 0 by construction.
  - Total stall for one hazard = exactly LOAD_LAT cycles.
  - A new hazard detected in the first IDLE cycle after the wait starts a fresh sequence.
- Counters:
  - StallCnt increments on each clk with Stall_ID=1; FlushCnt increments on each clk with Flush_ID=1.
  - Both hold at all-ones (saturate, no wrap).
- Reset (rst=1 at clk edge): state=IDLE, cnt=0, StallCnt=FlushCnt=0.
  - While rst is high, Stall_IF, Stall_ID, Bubble_EX and Flush_ID are forced to 0.
  - Forwarding outputs stay purely combinational.
  - Reset in LU_WAIT aborts the stall; the next cycle after reset is IDLE.
- Latency:
  - Forward, stall and flush outputs are combinational from inputs and current state (0 cycles).
  - Counters update one cycle after the event.

Test Plan:
- Forward priority: RegWr_M=1, Rd_M=3, RegWr_WB=1, Rd_WB=3, Ra_EX=3 -> BusAFw=10. Then set RegWr_M=0 -> BusAFw=01. Then Ra_EX=0 with Rd_M=Rd_WB=0 -> 00.
- Store data: MemWr_M=1, Rb_M=7, RegWr_WB=1, Rd_WB=7 -> DiSrc=1. Rd_WB=0 -> DiSrc=0.
- Load-use, LOAD_LAT=3: MemRd_EX=RegWr_EX=1, Rd_EX=5, Ra_ID=5 -> Stall_ID/Bubble_EX high for exactly 3 cycles, then low. StallCnt=3.
  - Repeat with UseRb_ID=0, Rb_ID=5, Ra_ID=2 -> no stall.
- Branch vs hazard: lu conditions plus BrTaken_EX=1 in the same cycle -> Flush_ID=1, Stall_ID=0, FlushCnt=1, StallCnt unchanged.
- Reset mid-stall, LOAD_LAT=4: assert rst on the 2nd stall cycle -> next cycle Stall_ID=0, state IDLE, counters 0.
- Saturation, CNT_W=4: hold lu continuously for 20 cycles with LOAD_LAT=1 -> StallCnt reaches 15 and stays there.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// Forwarding, load-use stall and branch-flush control for the ID/EX/MEM/WB pipeline.
// Includes saturating stall and flush event counters.
module fwd_hazard_unit #(
    parameter int RADDR_W  = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [RADDR_W-1:0] Ra_ID,
    input  logic [RADDR_W-1:0] Rb_ID,
    input  logic               UseRb_ID,
    input  logic               RegWr_EX,
    input  logic               MemRd_EX,
    input  logic [RADDR_W-1:0] Rd_EX,
    input  logic [RADDR_W-1:0] Ra_EX,
    input  logic [RADDR_W-1:0] Rb_EX,
    input  logic               BrTaken_EX,
    input  logic               RegWr_M,
    input  logic               MemWr_M,
    input  logic [RADDR_W-1:0] Rd_M,
    input  logic [RADDR_W-1:0] Rb_M,
    input  logic               RegWr_WB,
    input  logic [RADDR_W-1:0] Rd_WB,
    output logic [1:0]         BusAFw,
    output logic [1:0]         BusBFw,
    output logic               DiSrc,
    output logic               Stall_IF,
    output logic               Stall_ID,
    output logic               Bubble_EX,
    output logic               Flush_ID,
    output logic [CNT_W-1:0]   StallCnt,
    output logic [CNT_W-1:0]   FlushCnt
);

    typedef enum logic [0:0] {IDLE, LU_WAIT} state_t;

    localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);

    state_t     state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic       lu;

    // MEM wins over WB only when MEM really writes; a bare address match must not hide WB.
    function automatic logic [1:0] fwd_sel(input logic               wr_m,
                                           input logic [RADDR_W-1:0] rd_m,
                                           input logic               wr_wb,
                                           input logic [RADDR_W-1:0] rd_wb,
                                           input logic [RADDR_W-1:0] rs);
        logic hit_m, hit_w;
        hit_m = wr_m  && (rd_m  != '0) && (rd_m  == rs);
        hit_w = wr_wb && (rd_wb != '0) && (rd_wb == rs);
        if (hit_m)      return 2'b10;
        else if (hit_w) return 2'b01;
        else            return 2'b00;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign BusAFw = fwd_sel(RegWr_M, Rd_M, RegWr_WB, Rd_WB, Ra_EX);
    assign BusBFw = fwd_sel(RegWr_M, Rd_M, RegWr_WB, Rd_WB, Rb_EX);
    assign DiSrc  = MemWr_M && RegWr_WB && (Rd_WB != '0) && (Rd_WB == Rb_M);

    assign lu = MemRd_EX && RegWr_EX && (Rd_EX != '0) &&
                ((Rd_EX == Ra_ID) || (UseRb_ID && (Rd_EX == Rb_ID)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        Stall_IF  = 1'b0;
        Stall_ID  = 1'b0;
        Bubble_EX = 1'b0;
        Flush_ID  = 1'b0;
        case (state)
            IDLE: begin
                // A taken branch squashes the ID instruction, so its hazard is moot.
                if (BrTaken_EX) begin
                    Flush_ID  = 1'b1;
                    Bubble_EX = 1'b1;
                end else if (lu) begin
                    Stall_IF  = 1'b1;
                    Stall_ID  = 1'b1;
                    Bubble_EX = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_nxt = LU_WAIT;
                        cnt_nxt   = LAT_M1;
                    end
                end
            end
            LU_WAIT: begin
                Stall_IF  = 1'b1;
                Stall_ID  = 1'b1;
                Bubble_EX = 1'b1;
                cnt_nxt   = cnt - 3'd1;
                if (cnt == 3'd1) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
        if (rst) begin
            Stall_IF  = 1'b0;
            Stall_ID  = 1'b0;
            Bubble_EX = 1'b0;
            Flush_ID  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            if (Stall_ID) StallCnt <= sat_inc(StallCnt);
            if (Flush_ID) FlushCnt <= sat_inc(FlushCnt);
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: three instances with LOAD_LAT 3, 4 and 1 (the last with 4-bit counters).
module tb_fwd_hazard_unit;

    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] Ra_ID, Rb_ID, Rd_EX, Ra_EX, Rb_EX, Rd_M, Rb_M, Rd_WB;
    logic          UseRb_ID, RegWr_EX, MemRd_EX, BrTaken_EX, RegWr_M, MemWr_M, RegWr_WB;

    logic [1:0]  a_afw, a_bfw, b_afw, b_bfw, c_afw, c_bfw;
    logic        a_di, a_sif, a_sid, a_bub, a_fl;
    logic        b_di, b_sif, b_sid, b_bub, b_fl;
    logic        c_di, c_sif, c_sid, c_bub, c_fl;
    logic [31:0] a_sc, a_fc, b_sc, b_fc;
    logic [3:0]  c_sc, c_fc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.RADDR_W(RW), .LOAD_LAT(3), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .Ra_ID(Ra_ID), .Rb_ID(Rb_ID), .UseRb_ID(UseRb_ID),
        .RegWr_EX(RegWr_EX), .MemRd_EX(MemRd_EX), .Rd_EX(Rd_EX), .Ra_EX(Ra_EX), .Rb_EX(Rb_EX),
        .BrTaken_EX(BrTaken_EX), .RegWr_M(RegWr_M), .MemWr_M(MemWr_M), .Rd_M(Rd_M), .Rb_M(Rb_M),
        .RegWr_WB(RegWr_WB), .Rd_WB(Rd_WB), .BusAFw(a_afw), .BusBFw(a_bfw), .DiSrc(a_di),
        .Stall_IF(a_sif), .Stall_ID(a_sid), .Bubble_EX(a_bub), .Flush_ID(a_fl),
        .StallCnt(a_sc), .FlushCnt(a_fc));

    fwd_hazard_unit #(.RADDR_W(RW), .LOAD_LAT(4), .CNT_W(32)) dut_b (
        .clk(clk), .rst(rst), .Ra_ID(Ra_ID), .Rb_ID(Rb_ID), .UseRb_ID(UseRb_ID),
        .RegWr_EX(RegWr_EX), .MemRd_EX(MemRd_EX), .Rd_EX(Rd_EX), .Ra_EX(Ra_EX), .Rb_EX(Rb_EX),
        .BrTaken_EX(BrTaken_EX), .RegWr_M(RegWr_M), .MemWr_M(MemWr_M), .Rd_M(Rd_M), .Rb_M(Rb_M),
        .RegWr_WB(RegWr_WB), .Rd_WB(Rd_WB), .BusAFw(b_afw), .BusBFw(b_bfw), .DiSrc(b_di),
        .Stall_IF(b_sif), .Stall_ID(b_sid), .Bubble_EX(b_bub), .Flush_ID(b_fl),
        .StallCnt(b_sc), .FlushCnt(b_fc));

    fwd_hazard_unit #(.RADDR_W(RW), .LOAD_LAT(1), .CNT_W(4)) dut_c (
        .clk(clk), .rst(rst), .Ra_ID(Ra_ID), .Rb_ID(Rb_ID), .UseRb_ID(UseRb_ID),
        .RegWr_EX(RegWr_EX), .MemRd_EX(MemRd_EX), .Rd_EX(Rd_EX), .Ra_EX(Ra_EX), .Rb_EX(Rb_EX),
        .BrTaken_EX(BrTaken_EX), .RegWr_M(RegWr_M), .MemWr_M(MemWr_M), .Rd_M(Rd_M), .Rb_M(Rb_M),
        .RegWr_WB(RegWr_WB), .Rd_WB(Rd_WB), .BusAFw(c_afw), .BusBFw(c_bfw), .DiSrc(c_di),
        .Stall_IF(c_sif), .Stall_ID(c_sid), .Bubble_EX(c_bub), .Flush_ID(c_fl),
        .StallCnt(c_sc), .FlushCnt(c_fc));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        Ra_ID = '0; Rb_ID = '0; UseRb_ID = 1'b0; RegWr_EX = 1'b0; MemRd_EX = 1'b0;
        Rd_EX = '0; Ra_EX = '0; Rb_EX = '0; BrTaken_EX = 1'b0; RegWr_M = 1'b0;
        MemWr_M = 1'b0; Rd_M = '0; Rb_M = '0; RegWr_WB = 1'b0; Rd_WB = '0;
    endtask

    task automatic set_lu(input logic [RW-1:0] rd, input logic [RW-1:0] ra,
                          input logic [RW-1:0] rb, input logic use_rb);
        MemRd_EX = 1'b1; RegWr_EX = 1'b1; Rd_EX = rd; Ra_ID = ra; Rb_ID = rb; UseRb_ID = use_rb;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        check("rst_stallcnt", a_sc, 32'd0);
        check("rst_flushcnt", a_fc, 32'd0);
        set_lu(5'd5, 5'd5, 5'd0, 1'b0);
        BrTaken_EX = 1'b1;
        #1;
        check("rst_forces_stall", 32'(a_sid), 32'd0);
        check("rst_forces_flush", 32'(a_fl), 32'd0);
        check("rst_forces_bubble", 32'(a_bub), 32'd0);
        clear_inputs();
        rst = 1'b0;
        tick();

        // Forwarding priority and register-0 exclusion
        RegWr_M = 1'b1; Rd_M = 5'd3; RegWr_WB = 1'b1; Rd_WB = 5'd3; Ra_EX = 5'd3; Rb_EX = 5'd3;
        #1;
        check("fwd_a_mem", 32'(a_afw), 32'd2);
        check("fwd_b_mem", 32'(a_bfw), 32'd2);
        RegWr_M = 1'b0;
        #1;
        check("fwd_a_wb_bare_mem_match", 32'(a_afw), 32'd1);
        Rb_EX = 5'd4;
        #1;
        check("fwd_b_none", 32'(a_bfw), 32'd0);
        RegWr_M = 1'b1; Rd_M = 5'd0; Rd_WB = 5'd0; Ra_EX = 5'd0; Rb_EX = 5'd0;
        #1;
        check("fwd_a_r0", 32'(a_afw), 32'd0);
        check("fwd_b_r0", 32'(a_bfw), 32'd0);
        Rd_M = 5'd9; Rb_EX = 5'd9; Rd_WB = 5'd6; Ra_EX = 5'd6;
        #1;
        check("fwd_split_a_wb", 32'(a_afw), 32'd1);
        check("fwd_split_b_mem", 32'(a_bfw), 32'd2);

        // Store-data forwarding
        clear_inputs();
        MemWr_M = 1'b1; Rb_M = 5'd7; RegWr_WB = 1'b1; Rd_WB = 5'd7;
        #1;
        check("disrc_hit", 32'(a_di), 32'd1);
        Rd_WB = 5'd0;
        #1;
        check("disrc_rd0", 32'(a_di), 32'd0);
        Rd_WB = 5'd7; MemWr_M = 1'b0;
        #1;
        check("disrc_no_store", 32'(a_di), 32'd0);
        clear_inputs();
        tick();

        // Load-use: LOAD_LAT=3 on dut_a, 1 on dut_c
        set_lu(5'd5, 5'd5, 5'd0, 1'b0);
        #1;
        check("lu_c1_stall_id", 32'(a_sid), 32'd1);
        check("lu_c1_stall_if", 32'(a_sif), 32'd1);
        check("lu_c1_bubble", 32'(a_bub), 32'd1);
        check("lu_c1_flush", 32'(a_fl), 32'd0);
        tick();
        clear_inputs();
        #1;
        check("lu_c2_stall_id", 32'(a_sid), 32'd1);
        check("lu_c2_bubble", 32'(a_bub), 32'd1);
        check("lu_lat1_done", 32'(c_sid), 32'd0);
        tick();
        check("lu_c3_stall_id", 32'(a_sid), 32'd1);
        tick();
        check("lu_end_stall_id", 32'(a_sid), 32'd0);
        check("lu_end_bubble", 32'(a_bub), 32'd0);
        check("lu_stallcnt", a_sc, 32'd3);
        tick();

        // Rb only matters when the ID instruction reads it
        set_lu(5'd5, 5'd2, 5'd5, 1'b0);
        #1;
        check("lu_rb_unused", 32'(a_sid), 32'd0);
        UseRb_ID = 1'b1;
        #1;
        check("lu_rb_used", 32'(a_sid), 32'd1);
        set_lu(5'd0, 5'd0, 5'd0, 1'b1);
        #1;
        check("lu_rd0", 32'(a_sid), 32'd0);

        // Branch beats a simultaneous hazard
        set_lu(5'd5, 5'd5, 5'd0, 1'b0);
        BrTaken_EX = 1'b1;
        #1;
        check("br_flush", 32'(a_fl), 32'd1);
        check("br_stall_id", 32'(a_sid), 32'd0);
        check("br_stall_if", 32'(a_sif), 32'd0);
        check("br_bubble", 32'(a_bub), 32'd1);
        tick();
        clear_inputs();
        #1;
        check("br_flushcnt", a_fc, 32'd1);
        check("br_stallcnt_held", a_sc, 32'd3);
        check("br_no_later_stall", 32'(a_sid), 32'd0);
        check("br_flush_one_cycle", 32'(a_fl), 32'd0);

        // Reset during a LOAD_LAT=4 stall
        do_reset();
        tick();
        set_lu(5'd8, 5'd8, 5'd0, 1'b0);
        #1;
        check("rstmid_c1", 32'(b_sid), 32'd1);
        tick();
        clear_inputs();
        #1;
        check("rstmid_c2", 32'(b_sid), 32'd1);
        rst = 1'b1;
        #1;
        check("rstmid_forced", 32'(b_sid), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("rstmid_after", 32'(b_sid), 32'd0);
        check("rstmid_cnt", b_sc, 32'd0);
        tick();
        check("rstmid_idle", 32'(b_sid), 32'd0);
        check("rstmid_cnt_held", b_sc, 32'd0);

        // Counter saturation, 4-bit counters, LOAD_LAT=1
        do_reset();
        tick();
        set_lu(5'd5, 5'd5, 5'd0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) check("sat_cnt14", 32'(c_sc), 32'd14);
            if (i == 15) check("sat_cnt15", 32'(c_sc), 32'd15);
        end
        check("sat_held", 32'(c_sc), 32'd15);
        check("sat_still_stalling", 32'(c_sid), 32'd1);
        clear_inputs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
